// File: rtl/pc_sequencer.sv
// pc_sequencer: architectural program counter with next-PC selection.
// Each cycle the next fetch address is one of: sequential, conditional
// branch, J-type jump or jump-register. Stall holds the PC, and halt
// freezes it until reset.
// Optional feature macro: PC_SEQUENCER_EXC_EN adds the exc/eret/epc ports,
// exception entry to EXC_VECTOR and return from exception.
//
// Handshake note: there is no valid/ready pairing here. Every control
// input is sampled on each rising edge. Priority is
// reset > exc > stall > halt > eret > npc_sel.
module pc_sequencer #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h00400000),
    parameter int               INSN_BYTES   = 4,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h80000180)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             halt,
    input  logic [1:0]       npc_sel,
    input  logic             br_taken,
    input  logic [15:0]      imm16,
    input  logic [25:0]      target26,
    input  logic [WIDTH-1:0] rs_data,
`ifdef PC_SEQUENCER_EXC_EN
    input  logic             exc,
    input  logic             eret,
    output logic [WIDTH-1:0] epc,
`endif
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] link_addr,
    output logic             halted,
    output logic             misaligned
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    localparam logic [1:0] SEL_SEQ = 2'd0;
    localparam logic [1:0] SEL_BR  = 2'd1;
    localparam logic [1:0] SEL_J   = 2'd2;
    localparam logic [1:0] SEL_JR  = 2'd3;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             halted_q, halted_d;
    logic             mis_q, mis_d;

    logic [WIDTH-1:0] seq_addr;
    logic [WIDTH-1:0] br_offset;
    logic [WIDTH-1:0] br_target;
    logic [WIDTH-1:0] j_target;
    logic [WIDTH-1:0] jr_target;

    // The exception path collapses to constants when the feature is off,
    // so the mux below stays the same in both builds.
    logic             exc_req;
    logic             eret_req;
    logic [WIDTH-1:0] epc_val;

`ifdef PC_SEQUENCER_EXC_EN
    logic [WIDTH-1:0] epc_q, epc_d;
    assign exc_req  = exc;
    assign eret_req = eret;
    assign epc_val  = epc_q;
    assign epc      = epc_q;
`else
    assign exc_req  = 1'b0;
    assign eret_req = 1'b0;
    assign epc_val  = EXC_VECTOR;
`endif

    // Candidate addresses. All arithmetic wraps modulo 2^WIDTH.
    // The jump keeps the upper bits of pc_plus4, not of pc.
    always_comb begin
        seq_addr  = pc_q + WIDTH'(INSN_BYTES);
        br_offset = {{(WIDTH-18){imm16[15]}}, imm16, 2'b00};
        br_target = br_taken ? (seq_addr + br_offset) : seq_addr;
        j_target  = (seq_addr & ~WIDTH'(28'hFFFFFFF)) | WIDTH'({target26, 2'b00});
        jr_target = {rs_data[WIDTH-1:2], 2'b00};
    end

    // Next-state and next-PC selection, in priority order.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        halted_d = halted_q;
        mis_d    = mis_q;
`ifdef PC_SEQUENCER_EXC_EN
        epc_d    = epc_q;
`endif
        if (state_q == ST_RUN) begin
            if (exc_req) begin
                pc_d = EXC_VECTOR;
`ifdef PC_SEQUENCER_EXC_EN
                epc_d = pc_q;
`endif
            end else if (!stall) begin
                if (halt) begin
                    // pc is not updated on the edge that enters HALTED.
                    state_d  = ST_HALTED;
                    halted_d = 1'b1;
                end else if (eret_req) begin
                    pc_d = epc_val;
                end else begin
                    case (npc_sel)
                        SEL_SEQ: pc_d = seq_addr;
                        SEL_BR:  pc_d = br_target;
                        SEL_J:   pc_d = j_target;
                        SEL_JR: begin
                            pc_d = jr_target;
                            if (rs_data[1:0] != 2'b00) begin
                                mis_d = 1'b1;
                            end
                        end
                    endcase
                end
            end
        end
    end

    // State registers. Reset overrides everything, including HALTED.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_VECTOR;
            halted_q <= 1'b0;
            mis_q    <= 1'b0;
`ifdef PC_SEQUENCER_EXC_EN
            epc_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            halted_q <= halted_d;
            mis_q    <= mis_d;
`ifdef PC_SEQUENCER_EXC_EN
            epc_q    <= epc_d;
`endif
        end
    end

    assign pc         = pc_q;
    assign pc_plus4   = seq_addr;
    assign link_addr  = seq_addr;
    assign halted     = halted_q;
    assign misaligned = mis_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer. It uses directed vectors.
// A behavioural PC model is advanced by the driver at each edge.
// A single negedge process compares the DUT against the model every cycle.
// It also compares against hand-computed literals queued by the driver.
module tb_pc_sequencer;

    localparam logic [31:0] RV  = 32'h00400000;
    localparam logic [31:0] EXV = 32'h80000180;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        halt = 1'b0;
    logic [1:0]  npc_sel = 2'd0;
    logic        br_taken = 1'b0;
    logic [15:0] imm16 = '0;
    logic [25:0] target26 = '0;
    logic [31:0] rs_data = '0;
    logic [31:0] pc, pc_plus4, link_addr;
    logic        halted, misaligned;
`ifdef PC_SEQUENCER_EXC_EN
    logic        exc = 1'b0;
    logic        eret = 1'b0;
    logic [31:0] epc;
`endif

    pc_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .halt       (halt),
        .npc_sel    (npc_sel),
        .br_taken   (br_taken),
        .imm16      (imm16),
        .target26   (target26),
        .rs_data    (rs_data),
`ifdef PC_SEQUENCER_EXC_EN
        .exc        (exc),
        .eret       (eret),
        .epc        (epc),
`endif
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .link_addr  (link_addr),
        .halted     (halted),
        .misaligned (misaligned)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- model state ----------------
    logic [31:0] m_pc = '0;
    logic        m_halted = 1'b0;
    logic        m_mis = 1'b0;
    logic [31:0] m_epc = '0;
    logic        chk_en = 1'b0;

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic        halted;
        logic        mis;
        logic [31:0] epc;
    } lit_t;
    lit_t lit_q[$];

    int n_checks = 0;
    int n_fail = 0;

    // ---------------- scoreboard ----------------
    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("pc", pc, m_pc);
            cmp("pc_plus4", pc_plus4, m_pc + 32'd4);
            cmp("link_addr", link_addr, m_pc + 32'd4);
            cmp("halted", {31'd0, halted}, {31'd0, m_halted});
            cmp("misaligned", {31'd0, misaligned}, {31'd0, m_mis});
`ifdef PC_SEQUENCER_EXC_EN
            cmp("epc", epc, m_epc);
`endif
            while (lit_q.size() > 0) begin
                lit_t l;
                l = lit_q.pop_front();
                cmp($sformatf("lit%0d_pc", l.id), pc, l.pc);
                cmp($sformatf("lit%0d_model_pc", l.id), m_pc, l.pc);
                cmp($sformatf("lit%0d_halted", l.id), {31'd0, halted}, {31'd0, l.halted});
                cmp($sformatf("lit%0d_mis", l.id), {31'd0, misaligned}, {31'd0, l.mis});
`ifdef PC_SEQUENCER_EXC_EN
                cmp($sformatf("lit%0d_epc", l.id), epc, l.epc);
`endif
            end
        end
    end

    // ---------------- driver ----------------
    // Drives one cycle of inputs and advances the model across the edge.
    task automatic step(input logic rst, input logic st, input logic hl,
                        input logic [1:0] sel, input logic bt, input logic [15:0] imm,
                        input logic [25:0] tgt, input logic [31:0] rs);
        logic [31:0] n_pc, n_epc;
        logic        n_h, n_m;
        reset = rst; stall = st; halt = hl; npc_sel = sel;
        br_taken = bt; imm16 = imm; target26 = tgt; rs_data = rs;
        n_pc = m_pc; n_h = m_halted; n_m = m_mis; n_epc = m_epc;
        if (rst) begin
            n_pc = RV; n_h = 1'b0; n_m = 1'b0; n_epc = '0;
        end else if (!m_halted) begin
`ifdef PC_SEQUENCER_EXC_EN
            if (exc) begin
                n_epc = m_pc; n_pc = EXV;
            end else
`endif
            if (!st) begin
                if (hl) n_h = 1'b1;
`ifdef PC_SEQUENCER_EXC_EN
                else if (eret) n_pc = m_epc;
`endif
                else if (sel == 2'd0) n_pc = m_pc + 32'd4;
                else if (sel == 2'd1) n_pc = m_pc + 32'd4 + (bt ? 32'($signed(imm)) * 32'd4 : 32'd0);
                else if (sel == 2'd2) n_pc = ((m_pc + 32'd4) / 32'h10000000) * 32'h10000000 + {6'd0, tgt} * 32'd4;
                else begin
                    n_pc = rs - (rs % 32'd4);
                    if ((rs % 32'd4) != 0) n_m = 1'b1;
                end
            end
        end
        @(posedge clk);
        m_pc = n_pc; m_halted = n_h; m_mis = n_m; m_epc = n_epc;
        #1;
    endtask

    task automatic lit(input int id, input logic [31:0] p, input logic h, input logic m,
                       input logic [31:0] e);
        lit_t l;
        l.id = id; l.pc = p; l.halted = h; l.mis = m; l.epc = e;
        lit_q.push_back(l);
    endtask

    task automatic seq();                  step(0, 0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0); endtask
    task automatic br(input logic bt, input logic [15:0] imm); step(0, 0, 0, 2'd1, bt, imm, 26'h0, 32'h0); endtask
    task automatic jmp(input logic [25:0] t); step(0, 0, 0, 2'd2, 0, 16'h0, t, 32'h0); endtask
    task automatic jr(input logic [31:0] r);  step(0, 0, 0, 2'd3, 0, 16'h0, 26'h0, r); endtask

    initial begin
        step(1, 0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0);
        chk_en = 1'b1;
        lit(1, 32'h00400000, 0, 0, 0);
        seq(); lit(2, 32'h00400004, 0, 0, 0);
        seq(); lit(3, 32'h00400008, 0, 0, 0);
        seq(); lit(4, 32'h0040000C, 0, 0, 0);
        seq(); lit(5, 32'h00400010, 0, 0, 0);
        br(1, 16'hFFFC); lit(6, 32'h00400004, 0, 0, 0);
        seq(); seq(); seq(); lit(7, 32'h00400010, 0, 0, 0);
        br(0, 16'hFFFC); lit(8, 32'h00400014, 0, 0, 0);
        seq(); seq(); seq(); lit(9, 32'h00400020, 0, 0, 0);
        jmp(26'h0100008); lit(10, 32'h00400020, 0, 0, 0);
        jr(32'h00400031); lit(11, 32'h00400030, 0, 1, 0);
        seq(); seq(); lit(12, 32'h00400038, 0, 1, 0);
        // br_taken and rs_data are irrelevant for a sequential fetch
        step(0, 0, 0, 2'd0, 1, 16'hFFFC, 26'h0, 32'h3); lit(13, 32'h0040003C, 0, 1, 0);
        // halt is ignored while stalled
        step(0, 1, 1, 2'd0, 0, 16'h0, 26'h0, 32'h0); lit(14, 32'h0040003C, 0, 1, 0);
        step(0, 1, 0, 2'd2, 0, 16'h0, 26'h3FFFFFF, 32'h0);
        step(0, 1, 0, 2'd2, 0, 16'h0, 26'h3FFFFFF, 32'h0); lit(15, 32'h0040003C, 0, 1, 0);
        step(0, 0, 1, 2'd0, 0, 16'h0, 26'h0, 32'h0); lit(16, 32'h0040003C, 1, 1, 0);
        for (int i = 0; i < 5; i++) seq();
        lit(17, 32'h0040003C, 1, 1, 0);
        jr(32'h12345678); lit(18, 32'h0040003C, 1, 1, 0);
        step(1, 0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0); lit(19, 32'h00400000, 0, 0, 0);
        jr(32'hFFFFFFFC); lit(20, 32'hFFFFFFFC, 0, 0, 0);
        seq(); lit(21, 32'h00000000, 0, 0, 0);
        br(1, 16'hFFFE); lit(22, 32'hFFFFFFFC, 0, 0, 0);
        br(1, 16'h0001); lit(23, 32'h00000004, 0, 0, 0);
        jr(32'h0FFFFFFC); lit(24, 32'h0FFFFFFC, 0, 0, 0);
        jmp(26'h0); lit(25, 32'h10000000, 0, 0, 0);
        jmp(26'h3FFFFFF); lit(26, 32'h1FFFFFFC, 0, 0, 0);
        step(1, 1, 1, 2'd3, 0, 16'h0, 26'h0, 32'h1); lit(27, 32'h00400000, 0, 0, 0);
`ifdef PC_SEQUENCER_EXC_EN
        seq(); seq(); lit(28, 32'h00400008, 0, 0, 0);
        exc = 1'b1;
        step(0, 1, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0); lit(29, 32'h80000180, 0, 0, 32'h00400008);
        exc = 1'b0;
        seq(); lit(30, 32'h80000184, 0, 0, 32'h00400008);
        eret = 1'b1;
        step(0, 1, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0); lit(31, 32'h80000184, 0, 0, 32'h00400008);
        seq(); lit(32, 32'h00400008, 0, 0, 32'h00400008);
        eret = 1'b0;
        step(1, 0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0); lit(33, 32'h00400000, 0, 0, 32'h0);
`endif
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
